// File: rtl/buffering_multi_pkg.sv
// Shared types for the multi-ID request buffer: output FSM states, input routes and transaction sources.
package buffering_multi_pkg;

  typedef enum logic [1:0] {IDLE, DATA, XFER} out_state_t;
  typedef enum logic [1:0] {DIR, BUF, DROP} route_t;
  typedef enum logic {SRC_DIR, SRC_BUF} src_t;

  // A buffered transaction occupies one entry per beat.
  localparam int unsigned PAIR_ENTRIES = 2;
  localparam int unsigned DROP_CNT_W   = 16;

endpackage

// File: rtl/qs_fifo.sv
// Small synchronous FIFO with show-ahead read; occupancy is tracked by the instantiating block.
module qs_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/buffering_multi.sv
// Packs 2-beat stream transactions into device writes, parking masked IDs in a FIFO while opmode is low.
// Define BUFFERING_MULTI_DROP_EN to drop (and count) buffered transactions that find the FIFO full.
module buffering_multi
  import buffering_multi_pkg::*;
#(
  parameter int unsigned            DATA_W       = 16,
  parameter int unsigned            TID_W        = 3,
  parameter int unsigned            DEPTH        = 16,
  parameter logic [2**TID_W-1:0]    BUF_TID_MASK = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_tvalid_i,
  input  logic [TID_W-1:0]          req_tid_i,
  input  logic [DATA_W-1:0]         req_tdata_i,
  output logic                      req_tready_o,
  output logic                      dev_valid_o,
  output logic [DATA_W+TID_W-1:0]   dev_addr_o,
  output logic [DATA_W-1:0]         dev_data_o,
  input  logic                      dev_ready_i,
  input  logic                      dev_opmode_i,
  output logic [$clog2(DEPTH):0]    buf_level_o
`ifdef BUFFERING_MULTI_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_cnt_o
`endif
);

  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W  = TID_W + DATA_W;
  localparam int unsigned ADDR_W = DATA_W + TID_W;

  out_state_t          state_q, state_d;
  src_t                src_q, src_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    pairs_q, pairs_d;
  logic                drain_q, drain_d;
  logic                in_half_q, in_half_d;
  route_t              in_route_q, in_route_d;

  route_t              beat0_route_c, cur_route_c;
  logic                room_c, drain_sel_c, tready_c, acc_c;
  logic                push_c, pop_c, pair_push_c, pair_pop_c;
  logic [ENT_W-1:0]    pop_data_c;

  qs_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (~reset),
    .push_i      (push_c),
    .push_data_i ({req_tid_i, req_tdata_i}),
    .pop_i       (pop_c),
    .pop_data_o  (pop_data_c)
  );

  // Input router: route fixed at beat0, beat1 follows; BUF beat0 reserves room for its beat1.
  always_comb begin
    room_c      = (level_q <= LVL_W'(DEPTH - PAIR_ENTRIES));
    drain_sel_c = (state_q == IDLE) && (drain_q || (dev_opmode_i && (pairs_q != '0)));
    beat0_route_c = DIR;
    if (!dev_opmode_i && BUF_TID_MASK[req_tid_i]) begin
`ifdef BUFFERING_MULTI_DROP_EN
      beat0_route_c = room_c ? BUF : DROP;
`else
      beat0_route_c = BUF;
`endif
    end
    cur_route_c = in_half_q ? in_route_q : beat0_route_c;
    tready_c = 1'b0;
    if (!in_half_q) begin
      case (beat0_route_c)
        DIR:     tready_c = (state_q == IDLE) && !drain_sel_c;
        BUF:     tready_c = room_c;
        default: tready_c = 1'b1;
      endcase
    end else begin
      case (in_route_q)
        DIR:     tready_c = (state_q == DATA) && (src_q == SRC_DIR);
        default: tready_c = 1'b1;
      endcase
    end
    tready_c    = tready_c && reset;
    acc_c       = req_tvalid_i && tready_c;
    push_c      = acc_c && (cur_route_c == BUF);
    pair_push_c = push_c && in_half_q;
    pair_pop_c  = (state_q == DATA) && (src_q == SRC_BUF);
    pop_c       = drain_sel_c || pair_pop_c;
    in_half_d   = acc_c ? !in_half_q : in_half_q;
    in_route_d  = (acc_c && !in_half_q) ? beat0_route_c : in_route_q;
    level_d     = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    pairs_d     = pairs_q + LVL_W'(pair_push_c) - LVL_W'(pair_pop_c);
    drain_d     = (drain_q || drain_sel_c) && (pairs_d != '0);
  end

  // Output FSM: capture address beat, then data beat, then hold until the device takes it.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (drain_sel_c) begin
          addr_d  = {pop_data_c[DATA_W-1:0], pop_data_c[ENT_W-1:DATA_W]};
          src_d   = SRC_BUF;
          state_d = DATA;
        end else if (acc_c && !in_half_q && (beat0_route_c == DIR)) begin
          addr_d  = {req_tdata_i, req_tid_i};
          src_d   = SRC_DIR;
          state_d = DATA;
        end
      end
      DATA: begin
        if (src_q == SRC_BUF) begin
          data_d  = pop_data_c[DATA_W-1:0];
          valid_d = 1'b1;
          state_d = XFER;
        end else if (acc_c && in_half_q && (in_route_q == DIR)) begin
          data_d  = req_tdata_i;
          valid_d = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (dev_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= SRC_DIR;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      level_q    <= '0;
      pairs_q    <= '0;
      drain_q    <= 1'b0;
      in_half_q  <= 1'b0;
      in_route_q <= DIR;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      pairs_q    <= pairs_d;
      drain_q    <= drain_d;
      in_half_q  <= in_half_d;
      in_route_q <= in_route_d;
    end
  end

`ifdef BUFFERING_MULTI_DROP_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of transactions discarded at beat0.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (acc_c && !in_half_q && (beat0_route_c == DROP) && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign req_tready_o = tready_c;
  assign dev_valid_o  = valid_q;
  assign dev_addr_o   = addr_q;
  assign dev_data_o   = data_q;
  assign buf_level_o  = level_q;

endmodule

// File: tb/tb_buffering_multi.sv
// Directed bench for buffering_multi: direct path, buffer/drain, full, split pair, backpressure, reset, drop.
module tb_buffering_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_tvalid_i;
  logic [2:0]  req_tid_i;
  logic [15:0] req_tdata_i;
  logic        req_tready_o;
  logic        dev_valid_o;
  logic [18:0] dev_addr_o;
  logic [15:0] dev_data_o;
  logic        dev_ready_i;
  logic        dev_opmode_i;
  logic [4:0]  buf_level_o;
`ifdef BUFFERING_MULTI_DROP_EN
  logic [15:0] drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  buffering_multi dut (
    .clk          (clk),
    .reset        (reset),
    .req_tvalid_i (req_tvalid_i),
    .req_tid_i    (req_tid_i),
    .req_tdata_i  (req_tdata_i),
    .req_tready_o (req_tready_o),
    .dev_valid_o  (dev_valid_o),
    .dev_addr_o   (dev_addr_o),
    .dev_data_o   (dev_data_o),
    .dev_ready_i  (dev_ready_i),
    .dev_opmode_i (dev_opmode_i),
    .buf_level_o  (buf_level_o)
`ifdef BUFFERING_MULTI_DROP_EN
    ,
    .drop_cnt_o   (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [2:0] tid, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    req_tvalid_i = 1'b1;
    req_tid_i    = tid;
    req_tdata_i  = d;
    #1;
    while (!req_tready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("beat_timeout", 32'(req_tready_o), 32'd1);
    @(posedge clk);
    #1;
    req_tvalid_i = 1'b0;
  endtask

  task automatic send_txn(input logic [2:0] tid, input logic [15:0] a, input logic [15:0] d);
    send_beat(tid, a);
    send_beat(tid, d);
  endtask

  // Wait for a device write, check it and the FIFO level, then accept it.
  task automatic expect_dev(input string tag, input logic [18:0] a, input logic [15:0] d,
                            input logic [4:0] lvl);
    int n = 0;
    @(negedge clk);
    while (!dev_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(dev_valid_o), 32'd1);
    chk({tag, "_addr"},  32'(dev_addr_o),  32'(a));
    chk({tag, "_data"},  32'(dev_data_o),  32'(d));
    chk({tag, "_level"}, 32'(buf_level_o), 32'(lvl));
    dev_ready_i = 1'b1;
    @(posedge clk);
    #1;
    dev_ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a16;
    reset        = 1'b0;
    req_tvalid_i = 1'b0;
    req_tid_i    = '0;
    req_tdata_i  = '0;
    dev_ready_i  = 1'b0;
    dev_opmode_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(req_tready_o), 32'd0);
    chk("rst_valid",  32'(dev_valid_o),  32'd0);
    chk("rst_addr",   32'(dev_addr_o),   32'd0);
    chk("rst_data",   32'(dev_data_o),   32'd0);
    chk("rst_level",  32'(buf_level_o),  32'd0);
`ifdef BUFFERING_MULTI_DROP_EN
    chk("rst_drop",   32'(drop_cnt_o),   32'd0);
`endif
    reset = 1'b1;

    // Direct transaction
    @(negedge clk);
    dev_opmode_i = 1'b1;
    send_txn(3'd2, 16'h1234, 16'hABCD);
    expect_dev("t1", 19'h091A2, 16'hABCD, 5'd0);

    // Buffer three tid=5 transactions, then drain ahead of a direct one
    @(negedge clk);
    dev_opmode_i = 1'b0;
    send_txn(3'd5, 16'h0100, 16'h1111);
    send_txn(3'd5, 16'h0200, 16'h2222);
    send_txn(3'd5, 16'h0300, 16'h3333);
    repeat (3) @(negedge clk);
    chk("t2_novalid", 32'(dev_valid_o), 32'd0);
    chk("t2_level6",  32'(buf_level_o), 32'd6);
    dev_opmode_i = 1'b1;
    fork
      send_txn(3'd1, 16'h0400, 16'h4444);
      begin
        expect_dev("t2_d0",  19'h00805, 16'h1111, 5'd4);
        expect_dev("t2_d1",  19'h01005, 16'h2222, 5'd2);
        expect_dev("t2_d2",  19'h01805, 16'h3333, 5'd0);
        expect_dev("t2_dir", 19'h02001, 16'h4444, 5'd0);
      end
    join

`ifndef BUFFERING_MULTI_DROP_EN
    // Fill the FIFO; ninth beat0 stalls until one pair drains
    @(negedge clk);
    dev_opmode_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a16 = 16'h1000 + 16'(i);
      send_txn(3'd5, a16, 16'h2000 + 16'(i));
    end
    chk("t3_level16", 32'(buf_level_o), 32'd16);
    @(negedge clk);
    req_tvalid_i = 1'b1;
    req_tid_i    = 3'd5;
    req_tdata_i  = 16'h1008;
    #1;
    chk("t3_full_a", 32'(req_tready_o), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_full_b", 32'(req_tready_o), 32'd0);
    req_tvalid_i = 1'b0;
    dev_opmode_i = 1'b1;
    @(negedge clk);
    dev_opmode_i = 1'b0;
    send_txn(3'd5, 16'h1008, 16'h2008);
    chk("t3_refill", 32'(buf_level_o), 32'd16);
    for (int k = 0; k < 9; k++) begin
      a16 = 16'h1000 + 16'(k);
      expect_dev($sformatf("t3_d%0d", k), {a16, 3'd5}, 16'h2000 + 16'(k), 5'(16 - 2 * k));
    end
`endif

    // Split pair: beat1 after opmode rises is still buffered; tid of beat1 ignored
    @(negedge clk);
    dev_opmode_i = 1'b0;
    send_beat(3'd5, 16'h0AAA);
    @(negedge clk);
    dev_opmode_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_nodrain", 32'(dev_valid_o), 32'd0);
    chk("t4_half",    32'(buf_level_o), 32'd1);
    send_beat(3'd2, 16'h0BBB);
    expect_dev("t4", 19'h05555, 16'h0BBB, 5'd0);

    // Device backpressure: output held, direct beats stalled, buffered beats accepted
    send_txn(3'd3, 16'h0123, 16'h0456);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d", c), 32'(dev_valid_o), 32'd1);
    end
    chk("t5_addr", 32'(dev_addr_o), 32'h0091B);
    chk("t5_data", 32'(dev_data_o), 32'h0456);
    req_tvalid_i = 1'b1;
    req_tid_i    = 3'd3;
    req_tdata_i  = 16'h0999;
    #1;
    chk("t5_dir_stall", 32'(req_tready_o), 32'd0);
    dev_opmode_i = 1'b0;
    req_tid_i    = 3'd5;
    #1;
    chk("t5_buf_ready", 32'(req_tready_o), 32'd1);
    req_tvalid_i = 1'b0;
    send_txn(3'd5, 16'h0777, 16'h0888);
    chk("t5_level2", 32'(buf_level_o), 32'd2);
    expect_dev("t5", 19'h0091B, 16'h0456, 5'd2);

    // Reset in the middle of a drain
    send_txn(3'd5, 16'h0999, 16'h0AAA);
    chk("t6_level4", 32'(buf_level_o), 32'd4);
    @(negedge clk);
    dev_opmode_i = 1'b1;
    @(negedge clk);
    chk("t6_midpop", 32'(buf_level_o), 32'd3);
    reset = 1'b0;
    #1;
    chk("t6_rst_level", 32'(buf_level_o), 32'd0);
    chk("t6_rst_valid", 32'(dev_valid_o), 32'd0);
    chk("t6_rst_ready", 32'(req_tready_o), 32'd0);
    chk("t6_rst_addr",  32'(dev_addr_o),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_post_valid", 32'(dev_valid_o), 32'd0);
    chk("t6_post_level", 32'(buf_level_o), 32'd0);
    send_txn(3'd2, 16'h1234, 16'hABCD);
    expect_dev("t6_resume", 19'h091A2, 16'hABCD, 5'd0);

`ifdef BUFFERING_MULTI_DROP_EN
    // Full FIFO: extra buffered transaction is accepted and dropped
    @(negedge clk);
    dev_opmode_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a16 = 16'h3000 + 16'(i);
      send_txn(3'd5, a16, 16'h4000 + 16'(i));
    end
    chk("t7_level16", 32'(buf_level_o), 32'd16);
    send_txn(3'd5, 16'h3100, 16'h3101);
    chk("t7_drop_cnt", 32'(drop_cnt_o), 32'd1);
    chk("t7_level",    32'(buf_level_o), 32'd16);
    chk("t7_novalid",  32'(dev_valid_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
